// File: rtl/sd_buf_pkg.sv
// rtl/sd_buf_pkg.sv - CPU register offsets, block size and engine state encoding for the SD block buffer
package sd_buf_pkg;
  localparam logic [9:0] BLOCK_SIZE = 10'd512;

  localparam logic [5:0] REG_DATA      = 6'd0;
  localparam logic [5:0] REG_STATUS    = 6'd1;
  localparam logic [5:0] REG_FILL_CNT  = 6'd2;
  localparam logic [5:0] REG_SECTOR_LO = 6'd3;
  localparam logic [5:0] REG_SECTOR_HI = 6'd4;
  localparam logic [5:0] REG_CTRL      = 6'd5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SECT, ST_PUSH, ST_START, ST_POLL, ST_CHK, ST_DONE, ST_ERR
  } eng_state_t;
endpackage

// File: rtl/sd_buf_bank_ram.sv
// rtl/sd_buf_bank_ram.sv - 1024x8 ping-pong bank RAM, {bank, index} addressed, registered read
module sd_buf_bank_ram (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data
);
  logic [7:0] mem [0:1023];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/spmc_sd_block_buffer.sv
// rtl/spmc_sd_block_buffer.sv - CPU log-byte ping-pong buffer with a block-write engine driving the SD controller port
module spmc_sd_block_buffer
  import sd_buf_pkg::*;
#(
  parameter logic [9:0] BASE_ADR          = 10'h0,
  parameter logic [7:0] PAD_BYTE          = 8'h00,
  parameter logic [5:0] SD_REG_SECTOR     = 6'h07,
  parameter logic [5:0] SD_REG_TRANS_TYPE = 6'h02,
  parameter logic [5:0] SD_REG_TRANS_CTRL = 6'h03,
  parameter logic [5:0] SD_REG_TRANS_STS  = 6'h04,
  parameter logic [5:0] SD_REG_TRANS_ERR  = 6'h05,
  parameter logic [5:0] SD_REG_TX_FIFO    = 6'h20,
  parameter logic [7:0] SD_TYPE_BLK_WRITE = 8'h03
) (
  input  logic        clk_peri,
  input  logic        reset,
  input  logic [17:0] do_peri,
  output logic [17:0] di_peri,
  input  logic [9:0]  addr_peri,
  input  logic        access_peri,
  input  logic        wr_peri,
  output logic [5:0]  sd_addr_o,
  output logic [7:0]  sd_data_o,
  output logic        sd_strobe_o,
  output logic        sd_we_o,
  input  logic [7:0]  sd_data_i,
  output logic        sd_busy
);
  eng_state_t  state, state_nx;
  logic [9:0]  cnt, cnt_nx;
  logic [9:0]  fill_cnt;
  logic        fill_bank, pending, padding, err, ovf;
  logic [31:0] sector, sect_shift;
  logic [5:0]  ofs;
  logic        sel, cpu_wr, data_wr, ctrl_wr, full, busy, accept, clear_req;
  logic [7:0]  ram_rdata;
  logic        unused_bits;

  assign ofs         = addr_peri[5:0];
  assign sel         = access_peri && (addr_peri[9:6] == BASE_ADR[9:6]);
  assign cpu_wr      = sel && wr_peri;
  assign data_wr     = cpu_wr && (ofs == REG_DATA);
  assign ctrl_wr     = cpu_wr && (ofs == REG_CTRL);
  assign clear_req   = ctrl_wr && do_peri[1];
  assign full        = (fill_cnt == BLOCK_SIZE);
  assign busy        = (state != ST_IDLE);
  assign sd_busy     = busy;
  // padding owns the RAM write port; CPU bytes are only taken while there is room and no padding
  assign accept      = padding || (data_wr && !full);
  assign sect_shift  = sector << {cnt[1:0], 3'b000};
  assign unused_bits = ^do_peri[17:16];

  sd_buf_bank_ram u_ram (
    .clk     (clk_peri),
    .wr_en   (accept),
    .wr_addr ({fill_bank, fill_cnt[8:0]}),
    .wr_data (padding ? PAD_BYTE : do_peri[7:0]),
    .rd_addr ({~fill_bank, cnt[8:0]}),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge clk_peri) begin
    if (reset) begin
      fill_cnt  <= '0;
      fill_bank <= 1'b0;
      pending   <= 1'b0;
      padding   <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      sector    <= '0;
    end else begin
      if (data_wr && (padding || full)) ovf <= 1'b1;
      if (state == ST_CHK && state_nx == ST_ERR) err <= 1'b1;
      if (clear_req) begin
        err <= 1'b0;
        ovf <= 1'b0;
      end
      if (accept) begin
        if (fill_cnt == BLOCK_SIZE - 10'd1) begin
          padding <= 1'b0;
          if (!pending) begin
            fill_bank <= ~fill_bank;
            fill_cnt  <= '0;
            pending   <= 1'b1;
          end else begin
            fill_cnt <= BLOCK_SIZE;
          end
        end else begin
          fill_cnt <= fill_cnt + 10'd1;
        end
      end else if (full && !pending) begin
        fill_bank <= ~fill_bank;
        fill_cnt  <= '0;
        pending   <= 1'b1;
      end
      if (ctrl_wr && do_peri[0] && fill_cnt != 10'd0 && !full && !padding) padding <= 1'b1;
      if (state == ST_DONE) begin
        pending <= 1'b0;
        sector  <= sector + 32'd1;
      end
      if (cpu_wr && !busy && ofs == REG_SECTOR_LO) sector[15:0]  <= do_peri[15:0];
      if (cpu_wr && !busy && ofs == REG_SECTOR_HI) sector[31:16] <= do_peri[15:0];
    end
  end

  always_ff @(posedge clk_peri) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    sd_addr_o   = '0;
    sd_data_o   = '0;
    sd_strobe_o = 1'b0;
    sd_we_o     = 1'b0;
    case (state)
      ST_IDLE: if (pending) begin
        state_nx = ST_SECT;
        cnt_nx   = '0;
      end
      ST_SECT: begin
        sd_strobe_o = 1'b1;
        sd_we_o     = 1'b1;
        sd_addr_o   = SD_REG_SECTOR + {4'b0, cnt[1:0]};
        sd_data_o   = sect_shift[31:24];
        cnt_nx      = cnt + 10'd1;
        if (cnt[1:0] == 2'd3) begin
          state_nx = ST_PUSH;
          cnt_nx   = '0;
        end
      end
      // RAM read issued at cnt lands at cnt+1, so FIFO writes run on cnt 1..512
      ST_PUSH: begin
        if (cnt != 10'd0) begin
          sd_strobe_o = 1'b1;
          sd_we_o     = 1'b1;
          sd_addr_o   = SD_REG_TX_FIFO;
          sd_data_o   = ram_rdata;
        end
        if (cnt == BLOCK_SIZE) begin
          state_nx = ST_START;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      ST_START: begin
        sd_strobe_o = 1'b1;
        sd_we_o     = 1'b1;
        if (!cnt[0]) begin
          sd_addr_o = SD_REG_TRANS_TYPE;
          sd_data_o = SD_TYPE_BLK_WRITE;
          cnt_nx    = 10'd1;
        end else begin
          sd_addr_o = SD_REG_TRANS_CTRL;
          sd_data_o = 8'h01;
          state_nx  = ST_POLL;
          cnt_nx    = '0;
        end
      end
      ST_POLL: begin
        if (!cnt[0]) begin
          sd_strobe_o = 1'b1;
          sd_addr_o   = SD_REG_TRANS_STS;
          cnt_nx      = 10'd1;
        end else begin
          cnt_nx = '0;
          if (!sd_data_i[0]) state_nx = ST_CHK;
        end
      end
      ST_CHK: begin
        if (!cnt[0]) begin
          sd_strobe_o = 1'b1;
          sd_addr_o   = SD_REG_TRANS_ERR;
          cnt_nx      = 10'd1;
        end else begin
          cnt_nx   = '0;
          state_nx = (sd_data_i == 8'h00) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_ERR: if (clear_req) begin
        state_nx = ST_SECT;
        cnt_nx   = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    di_peri = '0;
    if (sel && !wr_peri) begin
      case (ofs)
        REG_STATUS:    di_peri = {14'b0, err, ovf, pending, busy};
        REG_FILL_CNT:  di_peri = {8'b0, fill_cnt};
        REG_SECTOR_LO: di_peri = {2'b0, sector[15:0]};
        REG_SECTOR_HI: di_peri = {2'b0, sector[31:16]};
        default:       di_peri = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_spmc_sd_block_buffer.sv
// tb/tb_spmc_sd_block_buffer.sv - register vector table plus block-transfer sequences against an SD controller model
module tb_spmc_sd_block_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] do_peri = '0;
  logic [17:0] di_peri;
  logic [9:0]  addr_peri = '0;
  logic        access_peri = 1'b0;
  logic        wr_peri = 1'b0;
  logic [5:0]  sd_addr_o;
  logic [7:0]  sd_data_o;
  logic        sd_strobe_o, sd_we_o, sd_busy;
  logic [7:0]  sd_data_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sect_q[$];
  logic [7:0] type_q[$];
  logic [7:0] ctrl_q[$];
  logic [7:0] exp_q[$];
  int sts_reads = 0;
  int err_reads = 0;
  int busy_until = 0;
  logic [7:0] err_reply = 8'h00;

  spmc_sd_block_buffer dut (
    .clk_peri(clk), .reset(reset), .do_peri(do_peri), .di_peri(di_peri),
    .addr_peri(addr_peri), .access_peri(access_peri), .wr_peri(wr_peri),
    .sd_addr_o(sd_addr_o), .sd_data_o(sd_data_o), .sd_strobe_o(sd_strobe_o),
    .sd_we_o(sd_we_o), .sd_data_i(sd_data_i), .sd_busy(sd_busy)
  );

  always #5 clk = ~clk;

  // controller model: records writes, answers reads for the following cycle
  always @(negedge clk) begin
    if (sd_strobe_o) begin
      if (sd_we_o) begin
        if (sd_addr_o >= 6'h07 && sd_addr_o <= 6'h0a) sect_q.push_back(sd_data_o);
        else if (sd_addr_o == 6'h20) fifo_q.push_back(sd_data_o);
        else if (sd_addr_o == 6'h02) type_q.push_back(sd_data_o);
        else if (sd_addr_o == 6'h03) ctrl_q.push_back(sd_data_o);
      end else if (sd_addr_o == 6'h04) begin
        sd_data_i = (sts_reads < busy_until) ? 8'h01 : 8'h00;
        sts_reads++;
      end else if (sd_addr_o == 6'h05) begin
        sd_data_i = err_reply;
        err_reads++;
      end else begin
        sd_data_i = 8'h00;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [17:0] d);
    access_peri = 1'b1; wr_peri = 1'b1; addr_peri = a; do_peri = d;
    @(negedge clk);
    access_peri = 1'b0; wr_peri = 1'b0;
  endtask

  task automatic cpu_read(input logic [9:0] a, output logic [17:0] d);
    access_peri = 1'b1; wr_peri = 1'b0; addr_peri = a;
    #1 d = di_peri;
    @(negedge clk);
    access_peri = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [9:0] a, input logic [17:0] exp);
    logic [17:0] d;
    cpu_read(a, d);
    check(name, {14'b0, d}, {14'b0, exp});
  endtask

  function automatic logic [7:0] pat(input int kind, input int i);
    case (kind)
      0: return 8'(i);
      1: return 8'(i * 3 + 1);
      2: return 8'(i) ^ 8'h5a;
      default: return 8'(255 - i);
    endcase
  endfunction

  task automatic write_block(input int kind);
    for (int i = 0; i < 512; i++) begin
      cpu_write(10'h000, {10'b0, pat(kind, i)});
      exp_q.push_back(pat(kind, i));
    end
  endtask

  task automatic wait_block(input string name);
    int n;
    n = 0;
    while (!sd_busy && n < 1000) begin @(negedge clk); n++; end
    check({name, "_busy_start"}, {31'b0, sd_busy}, 32'd1);
    n = 0;
    while (sd_busy && n < 5000) begin @(negedge clk); n++; end
    check({name, "_busy_end"}, {31'b0, sd_busy}, 32'd0);
  endtask

  task automatic check_fifo(input string name, input int base);
    int bad;
    bad = 0;
    check({name, "_fifo_count"}, fifo_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= fifo_q.size() || fifo_q[base + i] !== exp_q[i]) bad++;
    check({name, "_fifo_bad_bytes"}, bad, 0);
  endtask

  function automatic logic [31:0] sect_word(input int base);
    if (sect_q.size() < base + 4) return 32'hdeadbeef;
    return {sect_q[base], sect_q[base + 1], sect_q[base + 2], sect_q[base + 3]};
  endfunction

  typedef struct {
    logic [9:0]  addr;
    logic        wr;
    logic [17:0] wdata;
    logic [17:0] exp;
  } vec_t;
  vec_t vecs[15];

  initial begin
    int fb, sb, n;
    vecs[0]  = '{10'h001, 1'b0, 18'h0,     18'h0};
    vecs[1]  = '{10'h002, 1'b0, 18'h0,     18'h0};
    vecs[2]  = '{10'h003, 1'b0, 18'h0,     18'h0};
    vecs[3]  = '{10'h004, 1'b0, 18'h0,     18'h0};
    vecs[4]  = '{10'h003, 1'b1, 18'h31234, 18'h0};
    vecs[5]  = '{10'h004, 1'b1, 18'h0abcd, 18'h0};
    vecs[6]  = '{10'h003, 1'b0, 18'h0,     18'h01234};
    vecs[7]  = '{10'h004, 1'b0, 18'h0,     18'h0abcd};
    vecs[8]  = '{10'h000, 1'b1, 18'h11,    18'h0};
    vecs[9]  = '{10'h000, 1'b1, 18'h22,    18'h0};
    vecs[10] = '{10'h000, 1'b1, 18'h33,    18'h0};
    vecs[11] = '{10'h002, 1'b0, 18'h0,     18'h3};
    vecs[12] = '{10'h042, 1'b0, 18'h0,     18'h0};
    vecs[13] = '{10'h005, 1'b0, 18'h0,     18'h0};
    vecs[14] = '{10'h001, 1'b0, 18'h0,     18'h0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_strobe", {31'b0, sd_strobe_o}, 0);
    check("reset_busy", {31'b0, sd_busy}, 0);
    check("reset_addr", {26'b0, sd_addr_o}, 0);
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].wr) cpu_write(vecs[v].addr, vecs[v].wdata);
      else read_check($sformatf("vec%0d", v), vecs[v].addr, vecs[v].exp);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // full block of 0..255,0..255
    fb = fifo_q.size(); sb = sect_q.size(); exp_q.delete();
    write_block(0);
    wait_block("blkA");
    check_fifo("blkA", fb);
    check("blkA_sector_bytes", sect_word(sb), 32'h0);
    check("blkA_type", type_q.size() > 0 ? {24'b0, type_q[type_q.size() - 1]} : 32'hffff, 32'h03);
    check("blkA_ctrl", ctrl_q.size() > 0 ? {24'b0, ctrl_q[ctrl_q.size() - 1]} : 32'hffff, 32'h01);
    read_check("blkA_sector_lo", 10'h003, 18'h1);
    read_check("blkA_status", 10'h001, 18'h0);
    cpu_write(10'h005, 18'h1);
    repeat (5) @(negedge clk);
    read_check("empty_flush_status", 10'h001, 18'h0);

    // partial block flush, with a DATA write dropped during padding
    fb = fifo_q.size(); exp_q.delete();
    cpu_write(10'h000, 18'haa); cpu_write(10'h000, 18'hbb); cpu_write(10'h000, 18'hcc);
    read_check("flush_fill_cnt_pre", 10'h002, 18'h3);
    cpu_write(10'h005, 18'h1);
    cpu_write(10'h000, 18'h77);
    exp_q.push_back(8'haa); exp_q.push_back(8'hbb); exp_q.push_back(8'hcc);
    for (int i = 3; i < 512; i++) exp_q.push_back(8'h00);
    wait_block("flush");
    check_fifo("flush", fb);
    read_check("flush_fill_cnt_post", 10'h002, 18'h0);
    read_check("flush_status_ovf", 10'h001, 18'h4);
    cpu_write(10'h005, 18'h2);
    read_check("flush_status_cleared", 10'h001, 18'h0);

    // second bank fills while the first is stuck polling
    fb = fifo_q.size(); exp_q.delete();
    n = sts_reads;
    busy_until = sts_reads + 100;
    write_block(1);
    write_block(2);
    read_check("ovf_fill_cnt_full", 10'h002, 18'h200);
    read_check("ovf_status_pre", 10'h001, 18'h3);
    cpu_write(10'h000, 18'hee);
    read_check("ovf_status_set", 10'h001, 18'h7);
    wait_block("ovf_blk1");
    wait_block("ovf_blk2");
    check_fifo("ovf", fb);
    check("ovf_sts_reads", sts_reads - n, 102);
    read_check("ovf_sector_lo", 10'h003, 18'h4);
    read_check("ovf_status_post", 10'h001, 18'h4);
    cpu_write(10'h005, 18'h2);

    // controller reports an error, then a retry resends the same block
    fb = fifo_q.size(); exp_q.delete();
    n = err_reads;
    err_reply = 8'h01;
    write_block(3);
    for (int i = 0; i < 2000 && err_reads == n; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    read_check("err_status", 10'h001, 18'hb);
    cpu_write(10'h003, 18'h7777);
    read_check("err_sector_held", 10'h003, 18'h4);
    check_fifo("err_first", fb);
    err_reply = 8'h00;
    fb = fifo_q.size(); sb = sect_q.size();
    cpu_write(10'h005, 18'h2);
    wait_block("retry");
    check_fifo("retry", fb);
    check("retry_sector_bytes", sect_word(sb), 32'h4);
    read_check("retry_sector_lo", 10'h003, 18'h5);
    read_check("retry_status", 10'h001, 18'h0);

    // sector wrap
    fb = fifo_q.size(); sb = sect_q.size(); exp_q.delete();
    cpu_write(10'h003, 18'hffff);
    cpu_write(10'h004, 18'hffff);
    write_block(0);
    wait_block("wrap");
    check("wrap_sector_bytes", sect_word(sb), 32'hffffffff);
    read_check("wrap_sector_lo", 10'h003, 18'h0);
    read_check("wrap_sector_hi", 10'h004, 18'h0);

    // reset in the middle of PUSH
    fb = fifo_q.size(); exp_q.delete();
    write_block(1);
    for (int i = 0; i < 2000 && fifo_q.size() < fb + 10; i++) @(negedge clk);
    check("mid_push_reached", {31'b0, fifo_q.size() >= fb + 10}, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_strobe", {31'b0, sd_strobe_o}, 0);
    check("rst_we", {31'b0, sd_we_o}, 0);
    check("rst_addr", {26'b0, sd_addr_o}, 0);
    check("rst_data", {24'b0, sd_data_o}, 0);
    check("rst_busy", {31'b0, sd_busy}, 0);
    check("rst_di", {14'b0, di_peri}, 0);
    reset = 1'b0;
    fb = fifo_q.size();
    read_check("rst_fill_cnt", 10'h002, 18'h0);
    read_check("rst_status", 10'h001, 18'h0);
    repeat (20) @(negedge clk);
    check("rst_no_more_fifo", fifo_q.size() - fb, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spmc_sd_block_buffer.md
Name: spmc_sd_block_buffer

Overview:
- SpartanMC peripheral upstream of the SD card controller; the CPU streams log bytes into a ping-pong pair of 512-byte banks.
- When a bank fills, or the CPU requests a flush, an internal write engine drives the SD controller's register port.
- The engine loads the sector address and the 512 data bytes, starts a block write, polls for completion, then advances the sector.
- Top level muxes the controller port to this block whenever sd_busy=1.

Parameters:
BASE_ADR, 10'h0, peripheral base address, divisible by 64 (decoded from addr_peri[9:6])
PAD_BYTE, 8'h00, fill value for unwritten bytes on flush
SD_REG_SECTOR, 6'h07, controller address of sector byte 0 (MSB); bytes at +0..+3
SD_REG_TRANS_TYPE, 6'h02, controller transaction-type register
SD_REG_TRANS_CTRL, 6'h03, controller transaction-start register
SD_REG_TRANS_STS, 6'h04, controller status register (bit0 busy)
SD_REG_TRANS_ERR, 6'h05, controller error register (nonzero = error)
SD_REG_TX_FIFO, 6'h20, controller TX FIFO data port
SD_TYPE_BLK_WRITE, 8'h03, transaction-type code for a block write

Ports:
clk_peri  in  1  system clock
reset  in  1  synchronous, active-high reset
do_peri  in  18  CPU write data
di_peri  out  18  CPU read data; 0 when not selected or during a write
addr_peri  in  10  CPU address
access_peri  in  1  peripheral access strobe
wr_peri  in  1  CPU write enable
sd_addr_o  out  6  controller register address
sd_data_o  out  8  controller write data
sd_strobe_o  out  1  controller access strobe, one cycle per access
sd_we_o  out  1  controller write enable
sd_data_i  in  8  controller read data, valid the cycle after strobe
sd_busy  out  1  engine owns the controller port

Behaviour:
- CPU map, offset addr_peri[5:0]:
  - 0 DATA: write appends do_peri[7:0] at fill index.
  - 1 STATUS: read {14'b0, err, ovf, pending, busy}.
  - 2 FILL_CNT: read 10-bit byte count in the fill bank.
  - 3 SECTOR_LO / 4 SECTOR_HI: 16 bits each, read/write; writes are ignored while busy.
  - 5 CTRL: write-only; bit0 flush, bit1 clear err/ovf (also retries a failed block).
- Reset: all outputs 0; fill index 0; fill bank 0; pending=0; err=ovf=0; sector=0; FSM=IDLE.
- A DATA write with fill index 511 marks the bank full. If the other bank is not pending, swap banks, reset the fill index and set pending; otherwise hold the bank full.
- DATA write while fill bank is full and the swap is blocked: byte is dropped, ovf set (sticky).
- Flush with fill index 0: no effect. Otherwise pad with PAD_BYTE one byte per cycle up to 511, then treat as full. DATA writes during padding are dropped and set ovf.
- Engine FSM:
  - IDLE: on pending go to SECT.
  - SECT: 4 writes, sector[31:24] first, to SD_REG_SECTOR+0..3.
  - PUSH: 512 TX FIFO writes. Bank RAM has 1-cycle read latency, so the first write occurs one cycle after entry; one byte per cycle; 513 cycles total.
  - START: write SD_TYPE_BLK_WRITE to TRANS_TYPE, then 1 to TRANS_CTRL.
  - POLL: read TRANS_STS, sample next cycle; repeat while bit0=1.
  - CHK: read TRANS_ERR. If zero go to DONE, else go to ERR.
  - DONE: sector += 1 (32-bit wrap), clear pending, go to IDLE.
  - ERR: set err; hold the bank and sector; on clear go to SECT (retry).
- busy=1 in every state except IDLE. sd_we_o=1 only on write accesses.
- Simultaneous flush and a DATA write in the same cycle: the DATA write is applied first, then the flush.
- Reset mid-operation abandons the transfer. The controller is not notified; software reinitialises the card.

Decomposition:
- Package sd_buf_pkg: CPU register offsets, FSM state encoding, block size constant 512.
- Sub-module sd_buf_bank_ram: dual-port 1024x8 RAM with {bank, index} addressing; write port for CPU, read port for engine.

Test Plan:
- Reset, then write 512 bytes 0..255,0..255 -> SECT writes 00,00,00,00; 512 FIFO writes matching the data; TRANS_TYPE=03, CTRL=01; sector reads back 1.
- Write 3 bytes AA,BB,CC, then flush -> FIFO receives AA,BB,CC followed by 509×00; FILL_CNT reads 0 afterwards.
- Hold the model's TRANS_STS busy for 100 polls while 1024 more bytes are written -> bank B fills; the next DATA write sets ovf; no bytes are lost from either bank.
- Model returns TRANS_ERR=01 -> STATUS err=1, sector unchanged. Write CTRL=2 -> identical 512 bytes re-sent, sector increments.
- Set SECTOR to FFFF_FFFF and complete one block -> SECT bytes FF,FF,FF,FF; sector wraps to 0.
- Assert reset during PUSH -> next cycle all outputs 0, busy=0, FILL_CNT=0.
